// File: rtl/nmr_bstrm_simp_sramwr_if.sv
// Producer handshake and SRAM single-port bundle
// for the bitstream SRAM writer.
interface nmr_bstrm_simp_sramwr_if #(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 32,
  parameter int SRAM_BYTEEN_WIDTH = SRAM_DAT_WIDTH / 8
);
  logic                         START;
  logic [SRAM_ADDR_WIDTH-1:0]   BASE_ADDR;
  logic [SRAM_ADDR_WIDTH:0]     NUM_WORDS;
  logic [SRAM_DAT_WIDTH-1:0]    DATA_IN;
  logic                         DATA_VLD;
  logic                         DATA_ACK;
  logic                         SYS_RDY;
  logic                         DONE;
  logic                         WRAP_FLAG;
  logic                         SRAM_CS;
  logic                         SRAM_WE;
  logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN;
  logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR;
  logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT;

  modport master (
    output START, BASE_ADDR, NUM_WORDS,
    output DATA_IN, DATA_VLD,
    input  DATA_ACK, SYS_RDY, DONE, WRAP_FLAG,
    input  SRAM_CS, SRAM_WE, SRAM_BYTEEN,
    input  SRAM_ADDR, SRAM_WR_DAT
  );

  modport slave (
    input  START, BASE_ADDR, NUM_WORDS,
    input  DATA_IN, DATA_VLD,
    output DATA_ACK, SYS_RDY, DONE, WRAP_FLAG,
    output SRAM_CS, SRAM_WE, SRAM_BYTEEN,
    output SRAM_ADDR, SRAM_WR_DAT
  );
endinterface

// File: rtl/nmr_bstrm_simp_sramwr.sv
// Bitstream SRAM writer: fills a block of SRAM
// from a valid/ack producer, auto-incrementing address.
module nmr_bstrm_simp_sramwr #(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 32,
  parameter int SRAM_BYTEEN_WIDTH = SRAM_DAT_WIDTH / 8
) (
  input logic CLK,
  input logic RST,
  nmr_bstrm_simp_sramwr_if.slave bus
);
  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DW = SRAM_DAT_WIDTH;
  localparam int BW = SRAM_BYTEEN_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_WRITE = 4'b0100,
    S_FIN   = 4'b1000
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_reg;
  logic [AW:0]   len;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic [AW:0]   len_in;

  logic          sys_rdy;
  logic          data_ack;
  logic          done;
  logic          wrap_flag;
  logic          sram_cs;
  logic          sram_we;
  logic [BW-1:0] sram_byteen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wr_dat;

  assign cnt_nxt = cnt + {{AW{1'b0}}, 1'b1};

  // Counts beyond the SRAM depth collapse to a full-depth transfer.
  assign len_in = bus.NUM_WORDS[AW] ?
                  {1'b1, {AW{1'b0}}} : bus.NUM_WORDS;

  // Transfer FSM; every output is a register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      addr_reg    <= '0;
      len         <= '0;
      cnt         <= '0;
      sys_rdy     <= 1'b0;
      data_ack    <= 1'b0;
      done        <= 1'b0;
      wrap_flag   <= 1'b0;
      sram_cs     <= 1'b0;
      sram_we     <= 1'b0;
      sram_byteen <= '0;
      sram_addr   <= '0;
      sram_wr_dat <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.START && sys_rdy) begin
            addr_reg  <= bus.BASE_ADDR;
            len       <= len_in;
            cnt       <= '0;
            wrap_flag <= 1'b0;
            sys_rdy   <= 1'b0;
            if (len_in == '0) state <= S_FIN;
            else              state <= S_WAIT;
          end else begin
            sys_rdy <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.DATA_VLD) begin
            sram_wr_dat <= bus.DATA_IN;
            sram_addr   <= addr_reg;
            sram_cs     <= 1'b1;
            sram_we     <= 1'b1;
            sram_byteen <= '1;
            data_ack    <= 1'b1;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          sram_cs     <= 1'b0;
          sram_we     <= 1'b0;
          sram_byteen <= '0;
          data_ack    <= 1'b0;
          addr_reg    <= addr_reg + {{(AW-1){1'b0}}, 1'b1};
          if (&addr_reg) wrap_flag <= 1'b1;
          cnt <= cnt_nxt;
          if (cnt_nxt == len) state <= S_FIN;
          else                state <= S_WAIT;
        end
        S_FIN: begin
          done    <= 1'b1;
          sys_rdy <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.SYS_RDY     = sys_rdy;
  assign bus.DATA_ACK    = data_ack;
  assign bus.DONE        = done;
  assign bus.WRAP_FLAG   = wrap_flag;
  assign bus.SRAM_CS     = sram_cs;
  assign bus.SRAM_WE     = sram_we;
  assign bus.SRAM_BYTEEN = sram_byteen;
  assign bus.SRAM_ADDR   = sram_addr;
  assign bus.SRAM_WR_DAT = sram_wr_dat;
endmodule

// File: tb/tb_nmr_bstrm_simp_sramwr.sv
// Directed bench for the bitstream SRAM writer.
// Drives and samples on the falling clock edge.
module tb_nmr_bstrm_simp_sramwr;
  logic clk;
  logic rst;

  nmr_bstrm_simp_sramwr_if #(
    .SRAM_ADDR_WIDTH(8),
    .SRAM_DAT_WIDTH(32)
  ) bus ();

  nmr_bstrm_simp_sramwr #(
    .SRAM_ADDR_WIDTH(8),
    .SRAM_DAT_WIDTH(32)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  wr_addr [$];
  logic [31:0] wr_dat  [$];
  logic        wr_wrap [$];
  int          cs_cyc  [$];
  int          ack_cnt;
  int          done_cnt;
  int          done_cyc;
  int          we_bad;
  logic        wrap_t0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Passive log of SRAM writes, acks and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.SRAM_CS) begin
        wr_addr.push_back(bus.SRAM_ADDR);
        wr_dat.push_back(bus.SRAM_WR_DAT);
        wr_wrap.push_back(bus.WRAP_FLAG);
        cs_cyc.push_back(cyc);
        if (!bus.SRAM_WE || bus.SRAM_BYTEEN != 4'hF)
          we_bad++;
      end
      if (bus.DATA_ACK) ack_cnt++;
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clr_log();
    wr_addr.delete();
    wr_dat.delete();
    wr_wrap.delete();
    cs_cyc.delete();
    ack_cnt  = 0;
    done_cnt = 0;
    done_cyc = 0;
    we_bad   = 0;
  endtask

  task automatic xfer(input string tg,
                      input logic [7:0] base,
                      input logic [8:0] num,
                      input int stall,
                      input bit spur,
                      input logic [31:0] dbase);
    int nw, k, w, st, ba, bd, bs;
    logic [7:0] ea;
    bit fin;
    nw = (num > 9'd256) ? 256 : int'(num);
    @(negedge clk);
    clr_log();
    bus.START     = 1'b1;
    bus.BASE_ADDR = base;
    bus.NUM_WORDS = num;
    bus.DATA_IN   = dbase;
    bus.DATA_VLD  = (nw != 0);
    k   = cyc + 1;
    w   = 0;
    st  = 0;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      if (t == 0) begin
        wrap_t0 = bus.WRAP_FLAG;
        chk({tg, "_rdy_low"}, bus.SYS_RDY, 0);
      end
      if (spur && (t == 1 || t == 2)) begin
        bus.START     = 1'b1;
        bus.BASE_ADDR = 8'h77;
        bus.NUM_WORDS = 9'd1;
      end else begin
        bus.START = 1'b0;
      end
      if (bus.DATA_ACK) begin
        w++;
        if (w >= nw) begin
          bus.DATA_VLD = 1'b0;
        end else begin
          bus.DATA_IN = dbase + 32'(w);
          if (stall > 0) begin
            bus.DATA_VLD = 1'b0;
            st = stall;
          end
        end
      end else if (st > 0) begin
        st--;
        if (st == 0) bus.DATA_VLD = 1'b1;
      end
      if (bus.DONE) fin = 1'b1;
    end
    bus.START    = 1'b0;
    bus.DATA_VLD = 1'b0;
    chk({tg, "_done_seen"}, fin, 1);
    repeat (3) @(negedge clk);
    ba = 0;
    bd = 0;
    bs = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      ea = base + 8'(i);
      if (wr_addr[i] !== ea) ba++;
      if (wr_dat[i] !== dbase + 32'(i)) bd++;
      if (i > 0 && cs_cyc[i] - cs_cyc[i-1] != 2) bs++;
    end
    chk({tg, "_nwr"}, wr_addr.size(), nw);
    chk({tg, "_nack"}, ack_cnt, nw);
    chk({tg, "_ndone"}, done_cnt, 1);
    chk({tg, "_addr"}, ba, 0);
    chk({tg, "_data"}, bd, 0);
    chk({tg, "_we_be"}, we_bad, 0);
    chk({tg, "_rdy_end"}, bus.SYS_RDY, 1);
    if (stall == 0) begin
      chk({tg, "_lat"}, done_cyc - k, 2 * nw + 1);
      chk({tg, "_gap"}, bs, 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.START     = 1'b0;
    bus.BASE_ADDR = '0;
    bus.NUM_WORDS = '0;
    bus.DATA_IN   = '0;
    bus.DATA_VLD  = 1'b0;
    clr_log();
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.SYS_RDY, 0);
    chk("rst_cs", bus.SRAM_CS, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_addr", bus.SRAM_ADDR, 0);
    rst = 1'b0;
    chk("rel_rdy0", bus.SYS_RDY, 0);
    @(negedge clk);
    chk("rel_rdy1", bus.SYS_RDY, 1);

    xfer("basic", 8'h10, 9'd4, 0, 1'b0, 32'hA0);
    xfer("stall", 8'h20, 9'd3, 5, 1'b0, 32'h51);

    xfer("wrap", 8'hFE, 9'd4, 0, 1'b0, 32'hB0);
    chk("wrap_at_ff", wr_wrap[1], 0);
    chk("wrap_after_ff", wr_wrap[2], 1);
    chk("wrap_flag", bus.WRAP_FLAG, 1);

    xfer("zero", 8'h40, 9'd0, 0, 1'b0, 32'h0);
    chk("wrap_clr", wrap_t0, 0);

    xfer("full", 8'h00, 9'd256, 0, 1'b0, 32'h1000);
    xfer("clamp", 8'h40, 9'd300, 0, 1'b0, 32'h2000);
    xfer("spur", 8'h30, 9'd4, 0, 1'b1, 32'hC0);

    @(negedge clk);
    clr_log();
    bus.START     = 1'b1;
    bus.BASE_ADDR = 8'h10;
    bus.NUM_WORDS = 9'd4;
    bus.DATA_IN   = 32'hD0;
    bus.DATA_VLD  = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    for (int t = 0; t < 10 && !bus.SRAM_CS; t++)
      @(negedge clk);
    chk("ar_cs_pre", bus.SRAM_CS, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_cs", bus.SRAM_CS, 0);
    chk("ar_we", bus.SRAM_WE, 0);
    chk("ar_be", bus.SRAM_BYTEEN, 0);
    chk("ar_ack", bus.DATA_ACK, 0);
    chk("ar_rdy", bus.SYS_RDY, 0);
    chk("ar_addr", bus.SRAM_ADDR, 0);
    chk("ar_dat", bus.SRAM_WR_DAT, 0);
    chk("ar_wrap", bus.WRAP_FLAG, 0);
    bus.DATA_VLD = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("ar_rel_rdy0", bus.SYS_RDY, 0);
    @(negedge clk);
    chk("ar_rel_rdy1", bus.SYS_RDY, 1);
    repeat (12) @(negedge clk);
    chk("ar_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
